// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: load/store funct3 codes
// and the request FSM state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and a registered read
// port. The read register only updates on enabled cycles, so it holds steady.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, waits WAIT_STATES cycles,
// performs the byte-lane access and returns extended load data or an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        resp_err_q, resp_err_d;

    logic        access;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_funct3;
    logic        acc_err;
    logic        illegal, misaligned, in_range;
    logic [AW+1:0] offset;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // With zero wait states the access happens on the accepting edge, so the
    // live request is used instead of the not-yet-latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we     = req_we;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_we     = we_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_funct3 = funct3_q;
        end
    end

    always_comb begin
        illegal    = acc_we ? !(acc_funct3 inside {F3_B, F3_H, F3_W})
                            : !(acc_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((acc_funct3[1:0] == 2'd1) && acc_addr[0]) ||
                     ((acc_funct3[1:0] == 2'd2) && (acc_addr[1:0] != 2'd0));
        in_range   = (acc_addr >= BASE_ADDR) && ({1'b0, acc_addr} < LIMIT);
        acc_err    = illegal || misaligned || !in_range;
        offset     = acc_addr[AW+1:0] - BASE_ADDR[AW+1:0];
        case (acc_funct3[1:0])
            2'd0: begin
                ram_be    = 4'b0001 << acc_addr[1:0];
                ram_wdata = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                ram_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{acc_wdata[15:0]}};
            end
            default: begin
                ram_be    = 4'b1111;
                ram_wdata = acc_wdata;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        resp_err_d = resp_err_q;
        access     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            resp_err_d = acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            resp_err_q <= resp_err_d;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (access && !acc_err && !reset),
        .be   (acc_we ? ram_be : 4'b0000),
        .addr (offset[AW+1:2]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = ram_rdata[7:0];
            2'd1:    ld_byte = ram_rdata[15:8];
            2'd2:    ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'd0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = ram_rdata;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && resp_err_q;
    assign resp_rdata = (resp_valid && !we_q && !resp_err_q) ? ld_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses one wait state,
// instance 1 uses three wait states for the reset-in-WAIT scenario.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(1)) dut_ws1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    // Drives one request and completes the response handshake; lat counts
    // edges from the accepting edge until resp_valid is seen.
    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er, output int lat);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_funct3[d] = f3;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid[d]) begin
            checks++; errors++;
            $display("FAIL txn_timeout dut=%0d addr=%h got no resp_valid within %0d cycles", d, a, lat);
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_req_ready dut=%0d got=%b exp=1", d, req_ready[d]); end
            checks++; if (resp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid dut=%0d got=%b exp=0", d, resp_valid[d]); end
            checks++; if (resp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", d, resp_rdata[d]); end
            checks++; if (resp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut=%0d got=%b exp=0", d, resp_err[d]); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 3'd2, rd, er, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL back_to_back_ready got=%b exp=1", req_ready[0]); end
        txn(0, 1'b0, 32'h2004, 32'h0, 3'd2, rd, er, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL lw_word got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h2008, 32'h1122_3344, 3'd2, rd, er, lat);
        txn(0, 1'b1, 32'h2009, 32'hFFFF_FF80, 3'd0, rd, er, lat);
        txn(0, 1'b0, 32'h2009, 32'h0, 3'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin errors++; $display("FAIL lb_sign got=%h/%b exp=ffffff80/0", rd, er); end
        txn(0, 1'b0, 32'h2009, 32'h0, 3'd4, rd, er, lat);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero got=%h exp=00000080", rd); end
        txn(0, 1'b0, 32'h2008, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h1122_8044) begin errors++; $display("FAIL sb_lane1_only got=%h exp=11228044", rd); end
        txn(0, 1'b0, 32'h2008, 32'h0, 3'd1, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_8044) begin errors++; $display("FAIL lh_sign got=%h exp=ffff8044", rd); end
        txn(0, 1'b0, 32'h2008, 32'h0, 3'd5, rd, er, lat);
        checks++; if (rd !== 32'h0000_8044) begin errors++; $display("FAIL lhu_zero got=%h exp=00008044", rd); end
        txn(0, 1'b1, 32'h200A, 32'h0000_ABCD, 3'd1, rd, er, lat);
        txn(0, 1'b0, 32'h2008, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'hABCD_8044) begin errors++; $display("FAIL sh_upper got=%h exp=abcd8044", rd); end
        txn(0, 1'b0, 32'h200B, 32'h0, 3'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb_lane3 got=%h exp=ffffffab", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h2000, 32'hCAFE_F00D, 3'd2, rd, er, lat);
        txn(0, 1'b1, 32'h2003, 32'h0000_5555, 3'd1, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL sh_misaligned got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b0, 32'h2000, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL no_write_on_err got=%h/%b exp=cafef00d/0", rd, er); end
        txn(0, 1'b0, 32'h2001, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL lw_misaligned got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b0, 32'h2000, 32'h0, 3'd3, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL f3_illegal_load got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b1, 32'h2000, 32'h0, 3'd4, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL f3_illegal_store got=%b exp=1", er); end
        txn(0, 1'b0, 32'h1FFC, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL below_base got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b0, 32'h2400, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL past_end got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b1, 32'h23FC, 32'h0BAD_CAFE, 3'd2, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_store got=%b exp=0", er); end
        txn(0, 1'b0, 32'h23FC, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h0BAD_CAFE || er !== 1'b0) begin errors++; $display("FAIL last_word_load got=%h/%b exp=0badcafe/0", rd, er); end
        txn(0, 1'b0, 32'h2000, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL no_write_illegal_store got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h2014, 32'h0101_0101, 3'd2, rd, er, lat);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h2004; req_wdata[0] = 32'h0; req_funct3[0] = 3'd2;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (!resp_valid[0] && lat < 40) begin @(posedge clk); #1; lat++; end
        // Interfering store attempts while the response is stalled.
        req_we[0] = 1'b1; req_addr[0] = 32'h2014; req_wdata[0] = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = (i % 2 == 0);
            checks++; if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEAD_BEEF || resp_err[0] !== 1'b0)
                begin errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/deadbeef/0", i, resp_valid[0], resp_rdata[0], resp_err[0]); end
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, req_ready[0]); end
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_release got=%b/%b exp=0/1", resp_valid[0], req_ready[0]); end
        txn(0, 1'b0, 32'h2014, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h0101_0101) begin errors++; $display("FAIL ignored_req got=%h exp=01010101", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h2010, 32'hAAAA_5555, 3'd2, rd, er, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL ws3_latency got=%0d exp=4", lat); end
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h2010; req_wdata[1] = 32'h1234_5678; req_funct3[1] = 3'd2;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        reset[1] = 1'b1;
        @(posedge clk); #1;
        reset[1] = 1'b0;
        checks++; if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || resp_rdata[1] !== 32'h0 || resp_err[1] !== 1'b0)
            begin errors++; $display("FAIL wait_reset_outputs got=%b/%b/%h/%b exp=1/0/0/0", req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL wait_reset_dropped got=%b exp=0", resp_valid[1]); end
        txn(1, 1'b0, 32'h2010, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'hAAAA_5555 || er !== 1'b0) begin errors++; $display("FAIL wait_reset_no_write got=%h/%b exp=aaaa5555/0", rd, er); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h2018; req_wdata[0] = 32'h600D_D00D; req_funct3[0] = 3'd2;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (!resp_valid[0] && lat < 40) begin @(posedge clk); #1; lat++; end
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errors++; $display("FAIL resp_reset_outputs got=%b/%b exp=0/1", resp_valid[0], req_ready[0]); end
        txn(0, 1'b0, 32'h2018, 32'h0, 3'd2, rd, er, lat);
        checks++; if (rd !== 32'h600D_D00D) begin errors++; $display("FAIL resp_reset_store_kept got=%h exp=600dd00d", rd); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_funct3[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_reset_in_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port: it accepts one request at a time over a valid/ready handshake and applies a programmable number of wait states. It performs the word/halfword/byte access against an internal byte-lane RAM, then returns sign- or zero-extended load data, or an error, over a response handshake. It sits between the core's memory stage and on-chip data storage, and replaces the zero-latency combinational read path.

## Interface
- DEPTH_WORDS, 256: RAM size in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_2000: byte address of word 0; word-aligned.
- WAIT_STATES, 1: extra cycles between acceptance and response (0..15).
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_funct3  in  3  RISC-V funct3 of the load/store.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid is high, latch we, addr, wdata and funct3. Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), otherwise go to the access cycle directly.
  - WAIT: the counter decrements each cycle. At 0, perform the access and go to RESP.
  - RESP: resp_valid=1, outputs stable. When resp_ready is high, go to IDLE.
- Access, which happens on the edge entering RESP:
  - Error check first. No RAM write, rdata=0, err=1.
  - Loads: LB/LBU from lane addr[1:0]; LH/LHU from lane addr[1]*2; LW full word. LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: SB writes lane addr[1:0] from wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0]; SW writes all four lanes. Unwritten lanes keep their value.
- Error conditions:
  - Legal funct3: loads {0,1,2,4,5}; stores {0,1,2}. Anything else is illegal.
  - Misaligned: half at addr[0]=1; word at addr[1:0]≠0.
  - Out-of-range: addr < BASE_ADDR or addr ≥ BASE_ADDR + 4*DEPTH_WORDS.
- Only one outstanding request. req_ready=0 in WAIT and RESP. req_valid in those states is ignored and is not latched.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0. RAM contents are not reset.
- Latency: resp_valid rises exactly WAIT_STATES+1 cycles after the acceptance edge. With WAIT_STATES=0 it rises on the next cycle.
- Back-to-back: a response handshake in cycle N gives req_ready=1 in cycle N+1. Peak throughput is one request per WAIT_STATES+2 cycles.
- Backpressure: with resp_ready low, RESP holds indefinitely. rdata and err do not change. A store is committed once only.
- Store visibility: a load accepted after a store's response returns the new data.
- Reset in WAIT: no RAM write occurs, and the pending request is dropped. Reset in RESP: the already-committed store persists, and the response is dropped. In both cases the next cycle is IDLE with reset values.
- Address arithmetic is 32-bit unsigned. BASE_ADDR + 4*DEPTH_WORDS must not exceed 2^32. The RAM index is (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - the state enum {IDLE, WAIT, RESP}.
- Sub-module dmem_ram: DEPTH_WORDS×32 array with 4-bit byte-enable write and synchronous write/read on clk. dmem_responder owns the FSM, error check, lane steering and extension.

## Test plan
- WAIT_STATES=1: SW 0xDEADBEEF @0x2004, then LW @0x2004. Required: resp_rdata=0xDEADBEEF and err=0; resp_valid exactly 2 cycles after each acceptance.
- SB 0x80 @0x2009, then LB @0x2009 → 0xFFFFFF80; LBU → 0x00000080. A following LW @0x2008 shows only lane 1 changed.
- SH @0x2003 → err=1, rdata=0, no write. LW @0x2001 → err=1. funct3=3 load → err=1.
- LW @0x1FFC and @0x2000+4*DEPTH_WORDS → err=1. The last word @0x23FC (default depth) → err=0.
- resp_ready held low 5 cycles in RESP: resp_valid stays 1 and data stays stable. req_valid pulses are ignored. The stored value is written once.
- WAIT_STATES=3: reset asserted in the 2nd WAIT cycle of SW 0x12345678 @0x2010. Required: outputs return to reset values and the later LW @0x2010 returns the old data.
